hex_scan_drv: RTL
=================

HEX_SCAN_DRV -- requirements
Module: hex_scan_drv

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed hex digits (range 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit stays selected (minimum 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; when 1, segments and digit_sel are driven active-low.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port value  in  4*NUM_DIGITS  hex digits; digit 0 = bits [3:0] (rightmost).
REQ-007 SHALL have port dp_in  in  NUM_DIGITS  decimal point per digit, sampled with value.
REQ-008 SHALL have port load  in  1  one-cycle strobe that captures value and dp_in.
REQ-009 SHALL have port segments  out  8  {dp,a,b,c,d,e,f,g}; bit7 = dp, bit6 = a ... bit0 = g.
REQ-010 SHALL have port digit_sel  out  NUM_DIGITS  one-hot digit enable; bit i selects digit i.
REQ-011 SHALL have port frame  out  1  one-cycle pulse at each display-frame boundary.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; terminal count = tick.
REQ-013 Digit index SHALL advance on tick, 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
REQ-014 Frame boundary SHALL be the tick at which the index wraps from NUM_DIGITS-1 to 0; frame SHALL pulse high in the cycle after that tick.
REQ-015 load SHALL capture value/dp_in into a pending register and set pending_valid on the next edge.
REQ-016 Pending contents SHALL transfer to the active register only at a frame boundary, then clear pending_valid (no tearing mid-frame).
REQ-017 A load coinciding with a frame-boundary tick SHALL write the active register directly and leave pending_valid clear.
REQ-018 A second load before the boundary SHALL overwrite pending (last load wins).
REQ-019 Decode for the selected nibble, active-high abcdefg: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 B=1F C=4E D=3D E=4F F=47.
REQ-020 segments and digit_sel SHALL be registered, updating one cycle after the index changes.
REQ-021 Output polarity: ACTIVE_LOW=1 -> both buses inverted; ACTIVE_LOW=0 -> true polarity.
REQ-022 NUM_DIGITS=1 SHALL hold digit_sel constantly selected and pulse frame every tick.

Reset
REQ-023 While rst=1: prescaler=0, index=0, active=0, pending=0, pending_valid=0.
REQ-024 While rst=1: segments and digit_sel all off (all ones if ACTIVE_LOW=1), frame=0.
REQ-025 After rst falls, the first cycle SHALL select digit 0 showing the active (zero) contents; a load concurrent with rst SHALL be ignored.

Configuration
REQ-026 Macro HEX_SCAN_LZB_EN, when defined, SHALL blank leading zeros: any digit above the highest nonzero digit outputs all segments off, except digit 0 which always shows; dp still shows if its dp bit is set.
REQ-027 Without HEX_SCAN_LZB_EN, every digit SHALL be decoded, zeros included; no blanking logic is synthesised.

Verification (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1)
REQ-028 rst for 3 cycles -> segments=8'hFF, digit_sel=4'hF, frame=0 throughout.
REQ-029 load value=16'h12AF, dp_in=0, wait one frame -> digit 0 shows segments=~8'h47, digit 1 ~8'h77, digit 2 ~8'h6D, digit 3 ~8'h30; digit_sel cycles E,D,B,7, each for 4 cycles.
REQ-030 load 16'h1111 mid-frame (digit 1 selected) -> digits 2-3 still show the old value until the frame pulse, then all show ~8'h30.
REQ-031 load on the boundary tick, then a second load before the next boundary -> the first value shows at once; the second shows only after the next frame pulse.
REQ-032 HEX_SCAN_LZB_EN defined, load 16'h0005, dp_in=4'b0100 -> digit 3 = 8'hFF, digit 2 = ~8'h80, digit 1 = 8'hFF, digit 0 = ~8'h5B; undefined -> digits 1 and 3 show ~8'h7E.
REQ-033 Assert rst mid-frame with pending_valid=1 -> pending discarded, outputs off next cycle, scan restarts at digit 0.

Source files
------------

// File: rtl/hex_scan_drv.sv
// Multiplexed hex 7-segment scan driver with frame-synchronous (tear-free) display updates.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan_drv #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] active_val;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [4*NUM_DIGITS-1:0] pending_val;
    logic [NUM_DIGITS-1:0]   pending_dp;
    logic                    pending_valid;

    logic [4*NUM_DIGITS-1:0] val_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [6:0]              glyph;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   sel_next;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h7E;
            4'h1: decode = 7'h30;
            4'h2: decode = 7'h6D;
            4'h3: decode = 7'h79;
            4'h4: decode = 7'h33;
            4'h5: decode = 7'h5B;
            4'h6: decode = 7'h5F;
            4'h7: decode = 7'h70;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h7B;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h1F;
            4'hC: decode = 7'h4E;
            4'hD: decode = 7'h3D;
            4'hE: decode = 7'h4F;
            default: decode = 7'h47;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Display contents change only at the frame boundary, so a frame never mixes two values.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_val    <= '0;
            active_dp     <= '0;
            pending_val   <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                active_val <= value;
                active_dp  <= dp_in;
            end else if (pending_valid) begin
                active_val <= pending_val;
                active_dp  <= pending_dp;
            end
            pending_valid <= 1'b0;
        end else if (load) begin
            pending_val   <= value;
            pending_dp    <= dp_in;
            pending_valid <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        val_sh   = active_val >> {idx, 2'b00};
        dp_sh    = active_dp >> idx;
        glyph    = decode(val_sh[3:0]);
`ifdef HEX_SCAN_LZB_EN
        // val_sh holds this digit and every digit above it; all zero means a leading zero.
        if ((idx != '0) && (val_sh == '0)) begin
            glyph = 7'h00;
        end
`endif
        seg_next = {dp_sh[0], glyph};
        sel_next = NUM_DIGITS'(1) << idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segments  <= {8{ACTIVE_LOW}};
            digit_sel <= {NUM_DIGITS{ACTIVE_LOW}};
            frame     <= 1'b0;
        end else begin
            segments  <= seg_next ^ {8{ACTIVE_LOW}};
            digit_sel <= sel_next ^ {NUM_DIGITS{ACTIVE_LOW}};
            frame     <= wrap;
        end
    end

endmodule
